// File: rtl/noc_inter_control.sv
// Top-level sequencer for the FFN-intermediate datapath:
// load A -> load K -> matmul -> requant -> GELU -> requant -> write-back.
// Drives one-cycle start pulses to each stage and reports done/error to the host.
// All outputs are registered.
module noc_inter_control (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic done,
    output logic error,
    output logic start_dma_a,
    input  logic dma_a_done,
    input  logic dma_a_error,
    output logic start_dma_k,
    input  logic dma_k_done,
    input  logic dma_k_error,
    output logic start_dma_g,
    input  logic dma_g_done,
    input  logic dma_g_error,
    input  logic mm_done,
    output logic start_requant_mm,
    input  logic requant_mm_done,
    output logic start_gelu,
    input  logic gelu_done,
    output logic start_requant_gelu,
    input  logic requant_gelu_done
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StLoadA   = 4'd1,
        StLoadK   = 4'd2,
        StMm      = 4'd3,
        StReqMm   = 4'd4,
        StGelu    = 4'd5,
        StReqGelu = 4'd6,
        StWrite   = 4'd7,
        StDone    = 4'd8,
        StError   = 4'd9
    } state_e;

    state_e state_q, state_d;
    logic   g_seen_q, g_seen_d;
    logic   g_active;
    logic   entering;

    logic done_q, done_d;
    logic error_q, error_d;
    logic start_dma_a_q, start_dma_a_d;
    logic start_dma_k_q, start_dma_k_d;
    logic start_dma_g_q, start_dma_g_d;
    logic start_requant_mm_q, start_requant_mm_d;
    logic start_gelu_q, start_gelu_d;
    logic start_requant_gelu_q, start_requant_gelu_d;

    // Next-state: G write DMA runs alongside the pipeline, so its error aborts any later stage
    // and takes priority over that stage's own done.
    always_comb begin
        state_d  = state_q;
        g_active = (state_q == StMm) || (state_q == StReqMm) || (state_q == StGelu) ||
                   (state_q == StReqGelu) || (state_q == StWrite);
        case (state_q)
            StIdle: begin
                if (start) state_d = StLoadA;
            end
            StLoadA: begin
                if (dma_a_error)     state_d = StError;
                else if (dma_a_done) state_d = StLoadK;
            end
            StLoadK: begin
                if (dma_k_error)     state_d = StError;
                else if (dma_k_done) state_d = StMm;
            end
            StMm: begin
                if (dma_g_error)  state_d = StError;
                else if (mm_done) state_d = StReqMm;
            end
            StReqMm: begin
                if (dma_g_error)          state_d = StError;
                else if (requant_mm_done) state_d = StGelu;
            end
            StGelu: begin
                if (dma_g_error)    state_d = StError;
                else if (gelu_done) state_d = StReqGelu;
            end
            StReqGelu: begin
                if (dma_g_error)            state_d = StError;
                else if (requant_gelu_done) state_d = StWrite;
            end
            StWrite: begin
                if (dma_g_error)                   state_d = StError;
                else if (g_seen_q || dma_g_done)   state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StError: begin
                if (start) state_d = StLoadA;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sticky G-done flag: an early write-DMA completion must survive until WRITE is reached.
    always_comb begin
        g_seen_d = g_seen_q;
        if ((state_d == StMm) && (state_q != StMm)) begin
            g_seen_d = 1'b0;
        end else if (g_active && dma_g_done) begin
            g_seen_d = 1'b1;
        end
    end

    // Output decode: start pulses fire only on the edge that enters their state.
    always_comb begin
        entering             = (state_d != state_q);
        start_dma_a_d        = entering && (state_d == StLoadA);
        start_dma_k_d        = entering && (state_d == StLoadK);
        start_dma_g_d        = entering && (state_d == StMm);
        start_requant_mm_d   = entering && (state_d == StReqMm);
        start_gelu_d         = entering && (state_d == StGelu);
        start_requant_gelu_d = entering && (state_d == StReqGelu);
        done_d               = (state_d == StDone);
        error_d              = (state_d == StError);
    end

    // State, latch and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q              <= StIdle;
            g_seen_q             <= 1'b0;
            done_q               <= 1'b0;
            error_q              <= 1'b0;
            start_dma_a_q        <= 1'b0;
            start_dma_k_q        <= 1'b0;
            start_dma_g_q        <= 1'b0;
            start_requant_mm_q   <= 1'b0;
            start_gelu_q         <= 1'b0;
            start_requant_gelu_q <= 1'b0;
        end else begin
            state_q              <= state_d;
            g_seen_q             <= g_seen_d;
            done_q               <= done_d;
            error_q              <= error_d;
            start_dma_a_q        <= start_dma_a_d;
            start_dma_k_q        <= start_dma_k_d;
            start_dma_g_q        <= start_dma_g_d;
            start_requant_mm_q   <= start_requant_mm_d;
            start_gelu_q         <= start_gelu_d;
            start_requant_gelu_q <= start_requant_gelu_d;
        end
    end

    assign done               = done_q;
    assign error              = error_q;
    assign start_dma_a        = start_dma_a_q;
    assign start_dma_k        = start_dma_k_q;
    assign start_dma_g        = start_dma_g_q;
    assign start_requant_mm   = start_requant_mm_q;
    assign start_gelu         = start_gelu_q;
    assign start_requant_gelu = start_requant_gelu_q;

endmodule

// File: tb/tb_noc_inter_control.sv
// Bench for noc_inter_control: directed scenarios plus random input traffic, checked
// cycle by cycle against a stage-list reference model through a scoreboard queue.
module tb_noc_inter_control;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start, done, error;
    logic start_dma_a, dma_a_done, dma_a_error;
    logic start_dma_k, dma_k_done, dma_k_error;
    logic start_dma_g, dma_g_done, dma_g_error;
    logic mm_done, start_requant_mm, requant_mm_done;
    logic start_gelu, gelu_done, start_requant_gelu, requant_gelu_done;

    always #5 clk = ~clk;

    noc_inter_control dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .done               (done),
        .error              (error),
        .start_dma_a        (start_dma_a),
        .dma_a_done         (dma_a_done),
        .dma_a_error        (dma_a_error),
        .start_dma_k        (start_dma_k),
        .dma_k_done         (dma_k_done),
        .dma_k_error        (dma_k_error),
        .start_dma_g        (start_dma_g),
        .dma_g_done         (dma_g_done),
        .dma_g_error        (dma_g_error),
        .mm_done            (mm_done),
        .start_requant_mm   (start_requant_mm),
        .requant_mm_done    (requant_mm_done),
        .start_gelu         (start_gelu),
        .gelu_done          (gelu_done),
        .start_requant_gelu (start_requant_gelu),
        .requant_gelu_done  (requant_gelu_done)
    );

    // Input stimulus bit positions.
    localparam logic [10:0] I_START = 11'h001;
    localparam logic [10:0] I_A_DN  = 11'h002;
    localparam logic [10:0] I_A_ER  = 11'h004;
    localparam logic [10:0] I_K_DN  = 11'h008;
    localparam logic [10:0] I_K_ER  = 11'h010;
    localparam logic [10:0] I_G_DN  = 11'h020;
    localparam logic [10:0] I_G_ER  = 11'h040;
    localparam logic [10:0] I_MM    = 11'h080;
    localparam logic [10:0] I_RQM   = 11'h100;
    localparam logic [10:0] I_GELU  = 11'h200;
    localparam logic [10:0] I_RQG   = 11'h400;

    // Expected visible state for one cycle: state code + {done,error,sa,sk,sg,srm,sgelu,srg}.
    typedef struct packed {
        logic [3:0] st;
        logic [7:0] o;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_state = 0;
    logic m_gseen = 1'b0;

    task automatic drive(input logic [10:0] v);
        {requant_gelu_done, gelu_done, requant_mm_done, mm_done, dma_g_error, dma_g_done,
         dma_k_error, dma_k_done, dma_a_error, dma_a_done, start} = v;
    endtask

    task automatic cyc(input logic [10:0] v, input int n);
        drive(v);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset();
        logic [7:0] o;
        o = {done, error, start_dma_a, start_dma_k, start_dma_g, start_requant_mm,
             start_gelu, start_requant_gelu};
        n_tests++;
        if (dut.state_q !== 4'd0 || o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state t=%0t actual state=%0d outs=%b required state=0 outs=0",
                     $time, dut.state_q, o);
        end
    endtask

    // Waits a fixed window of n cycles with idle inputs; done must be seen within it.
    task automatic wait_done(input int n);
        bit seen;
        seen = 1'b0;
        drive('0);
        for (int i = 0; i <= n; i++) begin
            if (done === 1'b1) seen = 1'b1;
            if (i < n) begin
                @(posedge clk);
                #1;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_done t=%0t done not seen within %0d cycles", $time, n);
        end
    endtask

    // Reference model. Stages 1..7 form an ordered list; each has one completion input
    // (WRITE also accepts a remembered G completion) and a fault input. Stages 3..7
    // share the G write DMA fault. A start pulse belongs to stages 1..6 on arrival.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_state = 0;
                m_gseen = 1'b0;
                sb_q.push_back('0);
            end else begin
                logic [9:0] dn, er;
                int nxt;
                logic gs;
                exp_t e;
                dn = '0;
                er = '0;
                dn[1] = dma_a_done;        er[1] = dma_a_error;
                dn[2] = dma_k_done;        er[2] = dma_k_error;
                dn[3] = mm_done;           er[3] = dma_g_error;
                dn[4] = requant_mm_done;   er[4] = dma_g_error;
                dn[5] = gelu_done;         er[5] = dma_g_error;
                dn[6] = requant_gelu_done; er[6] = dma_g_error;
                dn[7] = dma_g_done | m_gseen;
                er[7] = dma_g_error;
                if (m_state == 0 || m_state == 9) nxt = start ? 1 : m_state;
                else if (m_state == 8)            nxt = 0;
                else if (er[m_state])             nxt = 9;
                else if (dn[m_state])             nxt = m_state + 1;
                else                              nxt = m_state;
                if (nxt == 3 && m_state != 3)                       gs = 1'b0;
                else if (m_state >= 3 && m_state <= 7 && dma_g_done) gs = 1'b1;
                else                                                gs = m_gseen;
                e.st = nxt[3:0];
                e.o  = '0;
                e.o[7] = (nxt == 8);
                e.o[6] = (nxt == 9);
                for (int s = 1; s <= 6; s++) begin
                    if (nxt == s && m_state != s) e.o[6-s] = 1'b1;
                end
                m_state = nxt;
                m_gseen = gs;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e, a;
                e = sb_q.pop_front();
                if (!rstn) e = '0;
                a.st = dut.state_q;
                a.o  = {done, error, start_dma_a, start_dma_k, start_dma_g, start_requant_mm,
                        start_gelu, start_requant_gelu};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check t=%0t actual state=%0d outs=%b required state=%0d outs=%b",
                             $time, a.st, a.o, e.st, e.o);
                end
            end
        end
    end

    // Full successful pipeline; optionally completes the G DMA early (during GELU).
    task automatic run_pipeline(input bit early_g);
        cyc(I_START, 1);
        cyc('0, 3);
        cyc(I_A_DN, 3);        // multi-cycle level done
        cyc('0, 3);
        cyc(I_K_DN, 1);
        cyc('0, 9);
        cyc(I_MM, 1);
        cyc('0, 1);
        cyc(I_RQM, 1);
        cyc('0, 2);
        cyc(early_g ? I_G_DN : 11'h000, 1);
        cyc('0, 1);
        cyc(I_GELU, 1);
        cyc('0, 1);
        cyc(I_RQG, 1);
        if (early_g) begin
            wait_done(3);
            cyc('0, 3);
        end else begin
            cyc('0, 3);
            cyc(I_G_DN, 1);
            wait_done(3);
        end
    endtask

    initial begin
        drive('0);
        #1;
        rstn = 1'b0;
        cyc(I_START, 5);       // start must be ignored while in reset
        check_reset();
        rstn = 1'b1;
        cyc('0, 2);

        run_pipeline(1'b0);

        // A DMA fault, then stray K done that must be ignored in ERROR
        cyc(I_START, 1);
        cyc('0, 1);
        cyc(I_A_ER, 1);
        cyc('0, 3);
        cyc(I_K_DN, 2);
        cyc('0, 2);

        // Recovery from ERROR with an early G completion
        run_pipeline(1'b1);

        // G fault coincident with requant MM done
        cyc(I_START, 1);
        cyc('0, 2);
        cyc(I_A_DN, 1);
        cyc('0, 2);
        cyc(I_K_DN, 1);
        cyc('0, 2);
        cyc(I_MM, 1);
        cyc('0, 1);
        cyc(I_RQM | I_G_ER, 1);
        cyc('0, 3);

        // Mid-run reset
        cyc(I_START, 1);
        cyc('0, 2);
        cyc(I_A_DN, 1);
        cyc('0, 2);
        rstn = 1'b0;
        cyc('0, 3);
        check_reset();
        rstn = 1'b1;
        cyc('0, 2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [10:0] v;
            v = '0;
            if ($urandom_range(0, 99) < 10) v |= I_START;
            if ($urandom_range(0, 99) < 30) v |= I_A_DN;
            if ($urandom_range(0, 99) < 2)  v |= I_A_ER;
            if ($urandom_range(0, 99) < 30) v |= I_K_DN;
            if ($urandom_range(0, 99) < 2)  v |= I_K_ER;
            if ($urandom_range(0, 99) < 15) v |= I_G_DN;
            if ($urandom_range(0, 99) < 2)  v |= I_G_ER;
            if ($urandom_range(0, 99) < 30) v |= I_MM;
            if ($urandom_range(0, 99) < 30) v |= I_RQM;
            if ($urandom_range(0, 99) < 30) v |= I_GELU;
            if ($urandom_range(0, 99) < 30) v |= I_RQG;
            if ($urandom_range(0, 999) < 3) rstn = 1'b0;
            else                            rstn = 1'b1;
            cyc(v, 1);
        end
        rstn = 1'b1;
        cyc('0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
